// File: rtl/rv32_decode_exec_mem.sv
// Single-cycle RV32I datapath slice: instruction decode/control, ALU and a
// byte-addressable data memory. The register file and PC live outside.
//
// Ports:
//   clk, reset          clock (memory writes on rising edge), async active-high reset
//   instr               current instruction
//   rv1, rv2            register values of rs1/rs2 (rv2 is also store data)
//   rs1, rs2, rd        register indices extracted from instr
//   reg_write           register write enable (never set for rd == x0)
//   mem_to_reg          writeback takes dmem_out (loads)
//   branch, jump, jalr  control-flow flags
//   auipc               external logic adds pc to imm
//   imm                 decoded, sign-extended immediate
//   alu_out             ALU result / effective address
//   alu_zero            branch-taken flag
//   we                  byte-lane write enables
//   dmem_out            load data, extended per load type
//   d0                  memory word 0 (debug)
module rv32_decode_exec_mem #(
    parameter int unsigned DMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [31:0] rv1,
    input  logic [31:0] rv2,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        branch,
    output logic        jump,
    output logic        jalr,
    output logic        auipc,
    output logic [31:0] imm,
    output logic [31:0] alu_out,
    output logic        alu_zero,
    output logic [3:0]  we,
    output logic [31:0] dmem_out,
    output logic [31:0] d0
);

    localparam int unsigned AW = $clog2(DMEM_WORDS);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic [31:0] mem_q [DMEM_WORDS];

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    logic [31:0] diff;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] rshift;
    logic [15:0] rhalf;
    logic [AW-1:0] widx;
    logic        wr_en;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign rd     = instr[11:7];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};

    assign diff = rv1 - rv2;

    function automatic logic [31:0] alu_fn(input logic [2:0] f3, input logic alt,
                                           input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        r = '0;
        case (f3)
            3'b000: r = alt ? (a - b) : (a + b);
            3'b001: r = a << b[4:0];
            3'b010: r = {31'b0, $signed(a) < $signed(b)};
            3'b011: r = {31'b0, a < b};
            3'b100: r = a ^ b;
            3'b101: begin
                if (alt) r = $unsigned($signed(a) >>> b[4:0]);
                else     r = a >> b[4:0];
            end
            3'b110: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    // Decode, ALU and store lane enables.
    always_comb begin
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        jalr       = 1'b0;
        auipc      = 1'b0;
        imm        = '0;
        alu_out    = '0;
        alu_zero   = 1'b0;
        we         = '0;
        wdata      = '0;
        unique case (opcode)
            OP_R: begin
                reg_write = 1'b1;
                // instr[30] only distinguishes SUB and SRA; other funct3 ignore it
                alu_out   = alu_fn(funct3, instr[30], rv1, rv2);
            end
            OP_I: begin
                reg_write = 1'b1;
                imm       = imm_i;
                // ADDI has no subtract form, so instr[30] only matters for SRAI
                alu_out   = alu_fn(funct3, (funct3 == 3'b101) && instr[30], rv1, imm_i);
            end
            OP_LOAD: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                imm        = imm_i;
                alu_out    = rv1 + imm_i;
            end
            OP_STORE: begin
                imm     = imm_s;
                alu_out = rv1 + imm_s;
                case (funct3)
                    3'b000: begin
                        we    = 4'b0001 << alu_out[1:0];
                        wdata = {4{rv2[7:0]}};
                    end
                    3'b001: begin
                        if (!alu_out[0]) we = alu_out[1] ? 4'b1100 : 4'b0011;
                        wdata = {2{rv2[15:0]}};
                    end
                    3'b010: begin
                        if (alu_out[1:0] == 2'b00) we = 4'b1111;
                        wdata = rv2;
                    end
                    default: ;
                endcase
            end
            OP_BRANCH: begin
                branch  = 1'b1;
                imm     = imm_b;
                alu_out = diff;
                case (funct3)
                    3'b000: alu_zero = (rv1 == rv2);
                    3'b001: alu_zero = (rv1 != rv2);
                    3'b100: alu_zero = ($signed(rv1) < $signed(rv2));
                    3'b101: alu_zero = ($signed(rv1) >= $signed(rv2));
                    3'b110: alu_zero = (rv1 < rv2);
                    3'b111: alu_zero = (rv1 >= rv2);
                    default: alu_zero = 1'b0;
                endcase
            end
            OP_JAL: begin
                jump      = 1'b1;
                reg_write = 1'b1;
                imm       = imm_j;
            end
            OP_JALR: begin
                jump      = 1'b1;
                jalr      = 1'b1;
                reg_write = 1'b1;
                imm       = imm_i;
                alu_out   = (rv1 + imm_i) & ~32'd1;
            end
            OP_LUI: begin
                reg_write = 1'b1;
                imm       = imm_u;
                alu_out   = imm_u;
            end
            OP_AUIPC: begin
                auipc     = 1'b1;
                reg_write = 1'b1;
                imm       = imm_u;
                alu_out   = imm_u;
            end
            default: ;
        endcase
        if (rd == 5'd0) reg_write = 1'b0;
    end

    // Upper address bits are dropped, so addresses wrap around the memory.
    assign widx  = alu_out[AW+1:2];
    assign rdata = mem_q[widx];
    assign wr_en = |we;

    // Loads read the aligned lane; misalignment within the lane is ignored.
    assign rshift = rdata >> {alu_out[1:0], 3'b000};
    assign rhalf  = alu_out[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        dmem_out = '0;
        if (opcode == OP_LOAD) begin
            case (funct3)
                3'b000: dmem_out = {{24{rshift[7]}}, rshift[7:0]};
                3'b001: dmem_out = {{16{rhalf[15]}}, rhalf};
                3'b010: dmem_out = rdata;
                3'b100: dmem_out = {24'b0, rshift[7:0]};
                3'b101: dmem_out = {16'b0, rhalf};
                default: dmem_out = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DMEM_WORDS; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (we[b]) mem_q[widx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign d0 = mem_q[0];

endmodule

// File: tb/tb_rv32_decode_exec_mem.sv
module tb_rv32_decode_exec_mem;

    logic        clk;
    logic        reset;
    logic [31:0] instr, rv1, rv2;
    logic [4:0]  rs1, rs2, rd;
    logic        reg_write, mem_to_reg, branch, jump, jalr, auipc, alu_zero;
    logic [31:0] imm, alu_out, dmem_out, d0;
    logic [3:0]  we;

    int n_total = 0;
    int n_bad   = 0;

    rv32_decode_exec_mem #(.DMEM_WORDS(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .instr     (instr),
        .rv1       (rv1),
        .rv2       (rv2),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .reg_write (reg_write),
        .mem_to_reg(mem_to_reg),
        .branch    (branch),
        .jump      (jump),
        .jalr      (jalr),
        .auipc     (auipc),
        .imm       (imm),
        .alu_out   (alu_out),
        .alu_zero  (alu_zero),
        .we        (we),
        .dmem_out  (dmem_out),
        .d0        (d0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic apply(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        instr = i;
        rv1   = a;
        rv2   = b;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        instr = 32'h0;
        rv1   = 32'h0;
        rv2   = 32'h0;
        #1;
        check("reset_d0", d0, 32'h0);
        check("reset_unknown_op_alu", alu_out, 32'h0);
        #2 reset = 1'b0;

        // ADDI x1,x0,-5
        apply(32'hFFB00093, 32'h0, 32'h0);
        check("addi_rd", {27'b0, rd}, 32'd1);
        check("addi_rw", {31'b0, reg_write}, 32'd1);
        check("addi_imm", imm, 32'hFFFFFFFB);
        check("addi_alu", alu_out, 32'hFFFFFFFB);
        check("addi_we", {28'b0, we}, 32'h0);
        // ADDI x1,x1,1024: instr[30]=1 must not turn into a subtract
        apply(32'h40008093, 32'h1, 32'h0);
        check("addi_bit30", alu_out, 32'h00000401);

        // SW x2,8(x1) then LW x3,8(x0)
        apply(32'h0020A423, 32'h0, 32'hDEADBEEF);
        check("sw_we", {28'b0, we}, 32'hF);
        check("sw_addr", alu_out, 32'd8);
        check("sw_rw", {31'b0, reg_write}, 32'd0);
        check("sw_rs1", {27'b0, rs1}, 32'd1);
        check("sw_rs2", {27'b0, rs2}, 32'd2);
        apply(32'h00802183, 32'h0, 32'h0);
        check("lw_data", dmem_out, 32'hDEADBEEF);
        check("lw_m2r", {31'b0, mem_to_reg}, 32'd1);

        // SB x2,5(x0) then LB/LBU/LH/LW
        apply(32'h002002A3, 32'h0, 32'h00000080);
        check("sb_we", {28'b0, we}, 32'h2);
        apply(32'h00500203, 32'h0, 32'h0);
        check("lb_data", dmem_out, 32'hFFFFFF80);
        apply(32'h00504203, 32'h0, 32'h0);
        check("lbu_data", dmem_out, 32'h00000080);
        apply(32'h00401203, 32'h0, 32'h0);
        check("lh_data", dmem_out, 32'hFFFF8000);
        apply(32'h00402203, 32'h0, 32'h0);
        check("lw4_data", dmem_out, 32'h00008000);

        // Branches
        apply(32'h00208463, 32'd7, 32'd7);
        check("beq_branch", {31'b0, branch}, 32'd1);
        check("beq_imm", imm, 32'd8);
        check("beq_taken", {31'b0, alu_zero}, 32'd1);
        check("beq_rw", {31'b0, reg_write}, 32'd0);
        apply(32'h00208463, 32'd7, 32'd8);
        check("beq_not", {31'b0, alu_zero}, 32'd0);
        check("beq_diff", alu_out, 32'hFFFFFFFF);
        apply(32'h00209463, 32'd7, 32'd8);
        check("bne_taken", {31'b0, alu_zero}, 32'd1);
        apply(32'h0020C463, 32'hFFFFFFFF, 32'd1);
        check("blt_signed", {31'b0, alu_zero}, 32'd1);
        apply(32'h0020E463, 32'hFFFFFFFF, 32'd1);
        check("bltu_unsigned", {31'b0, alu_zero}, 32'd0);
        apply(32'hFE208EE3, 32'd1, 32'd1);
        check("beq_neg_imm", imm, 32'hFFFFFFFC);

        // R-type and shifts
        apply(32'h4020D2B3, 32'h80000000, 32'd4);
        check("sra", alu_out, 32'hF8000000);
        check("sra_rd", {27'b0, rd}, 32'd5);
        apply(32'h0020D2B3, 32'h80000000, 32'd4);
        check("srl", alu_out, 32'h08000000);
        apply(32'h4040D093, 32'h80000000, 32'd0);
        check("srai", alu_out, 32'hF8000000);
        apply(32'h00000033, 32'd3, 32'd4);
        check("add_x0_rw", {31'b0, reg_write}, 32'd0);
        check("add_x0_alu", alu_out, 32'd7);
        apply(32'h402081B3, 32'd5, 32'd7);
        check("sub", alu_out, 32'hFFFFFFFE);
        apply(32'h0020A1B3, 32'hFFFFFFFF, 32'd1);
        check("slt", alu_out, 32'd1);
        apply(32'h0020B1B3, 32'hFFFFFFFF, 32'd1);
        check("sltu", alu_out, 32'd0);
        check("no_branch_zero", {31'b0, alu_zero}, 32'd0);

        // Jumps and upper immediates
        apply(32'h010000EF, 32'h0, 32'h0);
        check("jal_imm", imm, 32'd16);
        check("jal_flags", {28'b0, jump, jalr, reg_write, auipc}, 32'b1010);
        check("jal_alu", alu_out, 32'h0);
        apply(32'h003100E7, 32'h100, 32'h0);
        check("jalr_alu", alu_out, 32'h102);
        check("jalr_flags", {29'b0, jump, jalr, reg_write}, 32'b111);
        apply(32'h123452B7, 32'h0, 32'h0);
        check("lui_imm", imm, 32'h12345000);
        check("lui_alu", alu_out, 32'h12345000);
        apply(32'h12345297, 32'h0, 32'h0);
        check("auipc_flag", {31'b0, auipc}, 32'd1);
        check("auipc_alu", alu_out, 32'h12345000);
        apply(32'hFFFFFFFF, 32'h55, 32'h66);
        check("unk_imm", imm, 32'h0);
        check("unk_alu", alu_out, 32'h0);
        check("unk_ctrl", {25'b0, reg_write, mem_to_reg, branch, jump, jalr, auipc, alu_zero},
              32'h0);
        check("unk_we", {28'b0, we}, 32'h0);

        // Reset clears memory immediately and drops a coincident write
        apply(32'h00202023, 32'h0, 32'h12345678);
        apply(32'h00002183, 32'h0, 32'h0);
        check("sw0_d0", d0, 32'h12345678);
        @(negedge clk);
        reset = 1'b1;
        instr = 32'h00202023;
        rv2   = 32'hAAAAAAAA;
        #1;
        check("reset_async_d0", d0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        instr = 32'h00002183;
        #1;
        check("reset_drop_write", d0, 32'h0);
        apply(32'h00802183, 32'h0, 32'h0);
        check("reset_clears_w2", dmem_out, 32'h0);

        // Misaligned stores are suppressed; aligned SH writes the upper half
        apply(32'h00202023, 32'h0, 32'hCAFEF00D);
        apply(32'h00202123, 32'h0, 32'h11111111);
        check("sw_mis_we", {28'b0, we}, 32'h0);
        check("sw_mis_addr", alu_out, 32'd2);
        apply(32'h002010A3, 32'h0, 32'h00001234);
        check("sh_mis_we", {28'b0, we}, 32'h0);
        check("mis_unchanged", d0, 32'hCAFEF00D);
        apply(32'h00201123, 32'h0, 32'h0000ABCD);
        check("sh_we", {28'b0, we}, 32'hC);
        apply(32'h00002183, 32'h0, 32'h0);
        check("sh_d0", d0, 32'hABCDF00D);
        apply(32'h00201183, 32'h0, 32'h0);
        check("lh_hi", dmem_out, 32'hFFFFABCD);
        apply(32'h00205183, 32'h0, 32'h0);
        check("lhu_hi", dmem_out, 32'h0000ABCD);

        // Address 0x100 wraps onto word 0
        apply(32'h0020A023, 32'h100, 32'h00000055);
        check("wrap_we", {28'b0, we}, 32'hF);
        apply(32'h00002183, 32'h0, 32'h0);
        check("wrap_d0", d0, 32'h00000055);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/rv32_decode_exec_mem.md
Name:
rv32_decode_exec_mem

Overview:
- Single-cycle RV32I datapath slice: instruction decode/control, ALU, and byte-addressable data memory.
- The register file and PC register sit outside this block. It takes the fetched instruction plus register read values, and returns register indices, control flags, immediate, ALU result and load data.
- Decode, ALU and memory read are combinational; only memory writes are clocked.

Parameters:
- DMEM_WORDS, 64, number of 32-bit data-memory words (power of 2). Word index = addr[log2(DMEM_WORDS)+1:2]; upper address bits are ignored (wrap).

Ports:
- clk  in  1  clock; memory writes occur on the rising edge.
- reset  in  1  asynchronous, active-high; clears every memory word to 0.
- instr  in  32  current instruction.
- rv1  in  32  register-file value of rs1.
- rv2  in  32  register-file value of rs2; also the store data.
- rs1  out  5  instr[19:15].
- rs2  out  5  instr[24:20].
- rd  out  5  instr[11:7].
- reg_write  out  1  register write enable; forced 0 when rd==0.
- mem_to_reg  out  1  writeback selects dmem_out (loads).
- branch  out  1  conditional-branch instruction.
- jump  out  1  JAL or JALR.
- jalr  out  1  JALR.
- auipc  out  1  AUIPC; external logic adds pc to imm.
- imm  out  32  decoded, sign-extended immediate.
- alu_out  out  32  ALU result / effective address.
- alu_zero  out  1  branch-taken flag.
- we  out  4  byte-lane write enables driven to memory.
- dmem_out  out  32  load data, extended per load type.
- d0  out  32  memory word 0 (debug).

Behaviour:
- Decode uses opcode = instr[6:0]. Unlisted opcodes produce all flags 0, we=0, imm=0, alu_out=0.
- R-type (0110011):
  - Operation set: ADD, SUB (funct7[5]=1), SLL, SLT, SLTU, XOR, SRL, SRA (funct7[5]=1), OR, AND.
  - alu_out = rv1 op rv2; shift amount = rv2[4:0]; reg_write=1.
- I-ALU (0010011):
  - imm = sext(instr[31:20]); alu_out = rv1 op imm.
  - Shifts use instr[24:20]; SRAI is selected when instr[30]=1.
- Loads (0000011):
  - imm = I-type; address alu_out = rv1+imm; mem_to_reg=1; reg_write=1.
  - Lane selection: LB/LBU use byte addr[1:0]; LH/LHU use half addr[1]; LW uses the whole word.
  - Extension: LB/LH sign-extend, LBU/LHU zero-extend.
  - Reads are combinational from the addressed word. Misaligned loads use the aligned lane and never fault.
- Stores (0100011):
  - imm = sext({instr[31:25],instr[11:7]}); address = rv1+imm; reg_write=0.
  - we: SB = 4'b0001<<addr[1:0]; SH = 4'b0011 or 4'b1100 by addr[1]; SW = 4'b1111.
  - Misaligned SH (addr[0]=1) or SW (addr[1:0]!=0) gives we=0.
  - Write data: SB replicates rv2[7:0] into all lanes; SH replicates rv2[15:0]; SW uses rv2.
  - Enabled lanes update on the rising clk edge. A same-cycle read returns the old data.
- Branches (1100011):
  - imm = B-type sext; branch=1; alu_out = rv1-rv2.
  - alu_zero=1 iff the condition holds: BEQ, BNE, BLT, BGE (signed), BLTU, BGEU (unsigned).
  - alu_zero=0 for all non-branch opcodes.
- JAL (1101111): imm = J-type sext; jump=1; reg_write=1; alu_out=0.
- JALR (1100111): imm = I-type; jump=1; jalr=1; reg_write=1; alu_out = (rv1+imm) & ~1.
- LUI (0110111): imm = {instr[31:12],12'b0}; alu_out = imm; reg_write=1.
- AUIPC (0010111): same imm as LUI; auipc=1; reg_write=1; alu_out = imm.
- Arithmetic: 32-bit wrap-around with no overflow flag. SLT/SLTU return 0 or 1.
- Reset:
  - Asynchronous: all memory words read 0 immediately, and d0=0.
  - Combinational outputs do not depend on reset.
  - A write whose clock edge coincides with asserted reset is discarded.
- Simultaneous load and store are impossible (single instruction per cycle).

Test Plan:
- ADDI x1,x0,-5 (0xFFB00093), rv1=0 -> rd=1, reg_write=1, imm=0xFFFFFFFB, alu_out=0xFFFFFFFB, we=0.
- SW x2,8(x1) (0x0020A423), rv1=0, rv2=0xDEADBEEF -> we=4'b1111, alu_out=8.
  - After the clk edge, LW x3,8(x0) (0x00802183) -> dmem_out=0xDEADBEEF, mem_to_reg=1.
- SB x2,5(x0) (0x002002A3), rv2=0x00000080 -> we=4'b0010; after the edge:
  - LB x4,5(x0) (0x00500203) -> dmem_out=0xFFFFFF80.
  - LBU (0x00504203) -> dmem_out=0x00000080.
- BEQ x1,x2,+8 (0x00208463), rv1=rv2=7 -> branch=1, imm=8, alu_zero=1; with rv2=8 -> alu_zero=0.
- SRA x5,x1,x2 (0x4020D2B3), rv1=0x80000000, rv2=4 -> alu_out=0xF8000000; ADD x0,... -> reg_write=0.
- SW 0x12345678 to address 0, then assert reset between edges -> d0=0 at once. Misaligned SW at address 2 -> we=0, memory unchanged.
